// File: rtl/fpu_pkg.sv
// fpu: shared FPU datapath types (rounding mode, normalized result bundle)
package fpu;
  typedef enum logic [2:0] {
    FPU_RNE = 3'd0,
    FPU_RTZ = 3'd1,
    FPU_RDN = 3'd2,
    FPU_RUP = 3'd3,
    FPU_RMM = 3'd4
  } fpu_round_mode_t;
  typedef struct packed {
    logic            sign;
    logic [7:0]      exponent;
    logic [23:0]     mantissa;
    logic [2:0]      guard;
    logic            nan;
    logic            inf;
    logic            zero;
    fpu_round_mode_t mode;
  } fpu_result_t;
endpackage

// File: rtl/fpu_round_pkg.sv
// fpu_round: rounding-stage types, canonical NaN and the decide/pack functions
package fpu_round;
  import fpu::*;
  localparam logic [31:0] FPU_CANONICAL_NAN = 32'h7FC00000;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fpu_round_flags_t;
  typedef struct packed {
    fpu_result_t res;
    logic        invalid;
    logic        round_up;
    logic        inexact;
    logic        tiny;
  } fpu_round_stage1_t;
  typedef struct packed {
    logic [31:0]      data;
    fpu_round_flags_t flags;
  } fpu_round_out_t;
  function automatic fpu_round_stage1_t fpu_round_decide(input fpu_result_t r, input logic invalid);
    fpu_round_stage1_t s;
    s.res      = r;
    s.invalid  = invalid;
    s.inexact  = |r.guard;
    s.tiny     = r.exponent == 8'd0;
    s.round_up = (r.mode == FPU_RTZ) ? 1'b0 :
                 (r.mode == FPU_RDN) ? r.sign & s.inexact :
                 (r.mode == FPU_RUP) ? !r.sign & s.inexact :
                 (r.mode == FPU_RMM) ? r.guard[2] :
                 r.guard[2] & (|r.guard[1:0] | r.mantissa[0]);
    return s;
  endfunction
  function automatic fpu_round_out_t fpu_round_pack(input fpu_round_stage1_t s);
    fpu_round_out_t o;
    logic [24:0] sum;
    logic [8:0]  exp;
    logic [22:0] frac;
    logic        ovf;
    logic        to_inf;
    sum    = {1'b0, s.res.mantissa} + 25'(s.round_up);
    exp    = sum[24] ? {1'b0, s.res.exponent} + 9'd1 : (s.tiny & sum[23]) ? 9'd1 : {1'b0, s.res.exponent};
    frac   = sum[24] ? sum[23:1] : sum[22:0];
    ovf    = (exp >= 9'd255) | ((s.res.exponent == 8'hFE) & (&s.res.mantissa) & s.res.guard[2]);
    to_inf = !((s.res.mode == FPU_RTZ) | ((s.res.mode == FPU_RDN) & !s.res.sign) |
               ((s.res.mode == FPU_RUP) & s.res.sign));
    o.flags = '0;
    if (s.res.nan) begin
      o.data     = FPU_CANONICAL_NAN;
      o.flags.nv = s.invalid;
    end else if (s.res.inf) begin
      o.data = {s.res.sign, 8'hFF, 23'h0};
    end else if (s.res.zero) begin
      o.data = {s.res.sign, 31'h0};
    end else if (ovf) begin
      o.data     = to_inf ? {s.res.sign, 8'hFF, 23'h0} : {s.res.sign, 8'hFE, 23'h7FFFFF};
      o.flags.of = 1'b1;
      o.flags.nx = 1'b1;
    end else begin
      o.data     = {s.res.sign, exp[7:0], frac};
      o.flags.nx = s.inexact;
      o.flags.uf = s.tiny & s.inexact & (exp == 9'd0);
    end
    return o;
  endfunction
endpackage

// File: rtl/fpu_round_pack.sv
// fpu_round_pack: 2-stage round/pack pipeline (in_valid/in_ready/in_result/in_invalid -> out_valid/out_ready/out_data/out_flags)
module fpu_round_pack
  import fpu::*;
  import fpu_round::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  fpu_result_t in_result,
  input  logic        in_invalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_flags
);
  logic              r_s1_valid;
  fpu_round_stage1_t r_s1;
  logic              r_out_valid;
  logic [31:0]       r_out_data;
  logic [4:0]        r_out_flags;
  logic              w_s2_load;
  fpu_round_out_t    w_pack;
  assign w_s2_load = !r_out_valid | out_ready;
  assign in_ready  = !r_s1_valid | w_s2_load;
  assign w_pack    = fpu_round_pack(r_s1);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_s2_load) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data  <= w_pack.data;
          r_out_flags <= w_pack.flags;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (in_ready) r_s1 <= fpu_round_decide(in_result, in_invalid);
  end
endmodule
